// File: rtl/test_out_ej_buf_pkg.sv
// Shared widths and defaults for the test-output ejection buffer.
// Holds the timestamp width plus the VC-count and buffer-depth defaults.
package test_out_ej_buf_pkg;
  localparam int TS_WIDTH  = 16;
  localparam int N_VCS     = 2;
  localparam int VC_WIDTH  = 1;
  localparam int EJ_DEPTH  = 4;
  localparam int EJ_PTR_W  = 2;
endpackage

// File: rtl/test_out_ej_buf_if.sv
// Bundle between the router ejection port / test output consumer and the buffer.
// master = surrounding environment, slave = ejection buffer.
interface test_out_ej_buf_if;
  import test_out_ej_buf_pkg::*;
  logic                         in_valid;
  logic [VC_WIDTH-1:0]          in_vc;
  logic [TS_WIDTH-1:0]          in_ts;
  logic [N_VCS-1:0]             credit_out;
  logic [N_VCS*TS_WIDTH-1:0]    flit_ts;
  logic [N_VCS-1:0]             flit_valid;
  logic [N_VCS-1:0]             flit_deq;
  logic [TS_WIDTH-1:0]          sim_time;
  logic                         overflow;

  modport master (output in_valid, in_vc, in_ts, flit_deq, sim_time,
                  input  credit_out, flit_ts, flit_valid, overflow);
  modport slave  (input  in_valid, in_vc, in_ts, flit_deq, sim_time,
                  output credit_out, flit_ts, flit_valid, overflow);
endinterface

// File: rtl/test_out_ej_buf_flit_ts_fifo.sv
// Small synchronous FIFO of timestamps, one instance per VC.
// Push to a full FIFO and pop from an empty one are silently ignored.
module flit_ts_fifo
  import test_out_ej_buf_pkg::*;
#(
  parameter int W     = TS_WIDTH,
  parameter int DEPTH = EJ_DEPTH,
  parameter int PTR_W = EJ_PTR_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]            count_q, count_d;
  logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;
  logic                      do_push, do_pop;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    // DEPTH is a power of two, so pointer increment wraps on its own
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage is intentionally not reset
  always_ff @(posedge clock) mem_q <= mem_d;
endmodule

// File: rtl/test_out_ej_buf.sv
// Per-VC ejection buffer: one timestamp FIFO per VC, heads offered only once
// sim_time has reached them, one registered credit per accepted pop.
module test_out_ej_buf
  import test_out_ej_buf_pkg::*;
#(
  parameter int nVCs  = N_VCS,
  parameter int VC_W  = VC_WIDTH,
  parameter int DEPTH = EJ_DEPTH,
  parameter int PTR_W = EJ_PTR_W
) (
  input  logic               clock,
  input  logic               reset,
  test_out_ej_buf_if.slave   bus
);
  logic [nVCs-1:0]                 push, pop, full, empty;
  logic [nVCs-1:0][TS_WIDTH-1:0]   head;
  logic [nVCs-1:0][PTR_W:0]        count;
  logic [nVCs-1:0]                 credit_q, credit_d;
  logic                            overflow_q, overflow_d;

  for (genvar v = 0; v < nVCs; v++) begin : g_vc
    assign push[v] = bus.in_valid && (int'(bus.in_vc) == v);
    assign bus.flit_valid[v] = !empty[v] && (head[v] <= bus.sim_time);
    assign pop[v]  = bus.flit_deq[v] && bus.flit_valid[v];
    assign bus.flit_ts[v*TS_WIDTH +: TS_WIDTH] = head[v];

    flit_ts_fifo #(.W(TS_WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push[v]),
      .pop   (pop[v]),
      .din   (bus.in_ts),
      .head  (head[v]),
      .count (count[v]),
      .full  (full[v]),
      .empty (empty[v])
    );
  end

  // full is judged on the pre-edge count, so a same-cycle pop does not save a write
  always_comb begin
    credit_d   = pop;
    overflow_d = overflow_q | (|(push & full));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      credit_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.credit_out = credit_q;
  assign bus.overflow   = overflow_q;
endmodule
